// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Optional saturation build: define CLA_SATURATE_EN.
package cla_pkg;

   localparam int CLA_GRP_W = 4;
   localparam int CLA_MAX_W = 64;

   // Widest signed-max pattern; narrower limits are taken from its top bits.
   localparam logic [CLA_MAX_W-1:0] CLA_SMAX_FULL = {1'b0, {(CLA_MAX_W-1){1'b1}}};

   function automatic int cla_nstage(input int width, input int gps);
      return width / (CLA_GRP_W * gps);
   endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The sat field exists only when CLA_SATURATE_EN is defined.
interface cla_pipe_adder_if #(parameter int WIDTH = 16);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
`ifdef CLA_SATURATE_EN
   logic             sat;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             cout_prev;
   logic             ovf;
   logic             zero;

   modport master (
`ifdef CLA_SATURATE_EN
      output sat,
`endif
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, cout_prev, ovf, zero
   );

   modport slave (
`ifdef CLA_SATURATE_EN
      input  sat,
`endif
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, cout_prev, ovf, zero
   );

endinterface

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead group: sum, carry-out and the
// carry into bit 3 (needed for signed overflow at the MSB group).
module cla_group4
   import cla_pkg::*;
(
   input  logic [CLA_GRP_W-1:0] a,
   input  logic [CLA_GRP_W-1:0] b,
   input  logic                 ci,
   output logic [CLA_GRP_W-1:0] s,
   output logic                 co,
   output logic                 c3
);

   logic [CLA_GRP_W-1:0] p;
   logic [CLA_GRP_W-1:0] g;
   logic                 c1;
   logic                 c2;

   assign p = a ^ b;
   assign g = a & b;

   assign c1 = g[0] | (p[0] & ci);
   assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
   assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: GPS 4-bit groups per stage,
// latency WIDTH/(4*GPS). Define CLA_SATURATE_EN for the sat input.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int GPS   = 1
)
(
   input  logic           clk,
   input  logic           rst,
   cla_pipe_adder_if.slave bus
);

   localparam int NSTAGE = cla_nstage(WIDTH, GPS);
   localparam int SW     = CLA_GRP_W * GPS;
   localparam int LAST   = NSTAGE - 1;

   logic adv;

   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   for (genvar k = 0; k < NSTAGE; k++) begin : stg
      logic             v_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic [GPS:0]     gc;
      logic [GPS-1:0]   gc3;
      logic [SW-1:0]    gs;
      logic [WIDTH-1:0] s_nxt;

      logic             vld;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             cp_q;
`ifdef CLA_SATURATE_EN
      logic             sat_in;
      logic             sat_q;
`endif

      if (k == 0) begin : src
         assign v_in = bus.in_valid;
         assign a_in = bus.a;
         assign b_in = bus.sub ? ~bus.b : bus.b;
         assign c_in = bus.sub | bus.cin;
         assign s_in = '0;
`ifdef CLA_SATURATE_EN
         assign sat_in = bus.sat;
`endif
      end else begin : src
         assign v_in = stg[k-1].vld;
         assign a_in = stg[k-1].a_q;
         assign b_in = stg[k-1].b_q;
         assign c_in = stg[k-1].c_q;
         assign s_in = stg[k-1].s_q;
`ifdef CLA_SATURATE_EN
         assign sat_in = stg[k-1].sat_q;
`endif
      end

      assign gc[0] = c_in;

      for (genvar g = 0; g < GPS; g++) begin : grp
         localparam int LSB = (k * GPS + g) * CLA_GRP_W;
         cla_group4 u_grp (
            .a  (a_in[LSB +: CLA_GRP_W]),
            .b  (b_in[LSB +: CLA_GRP_W]),
            .ci (gc[g]),
            .s  (gs[g*CLA_GRP_W +: CLA_GRP_W]),
            .co (gc[g+1]),
            .c3 (gc3[g])
         );
      end

      // Bits resolved by earlier stages ride along; this stage fills its own slice.
      always_comb begin
         s_nxt             = s_in;
         s_nxt[k*SW +: SW] = gs;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld   <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
            cp_q  <= 1'b0;
`ifdef CLA_SATURATE_EN
            sat_q <= 1'b0;
`endif
         end else if (adv) begin
            vld   <= v_in;
            a_q   <= a_in;
            b_q   <= b_in;
            s_q   <= s_nxt;
            c_q   <= gc[GPS];
            cp_q  <= gc3[GPS-1];
`ifdef CLA_SATURATE_EN
            sat_q <= sat_in;
`endif
         end
      end

      // Operand bits below this stage's slice and cp_q before the last stage are dead.
      logic unused_stage;
      assign unused_stage = ^{a_q, b_q, cp_q, gc3};
   end

   logic [WIDTH-1:0] sum_fin;
   logic             ovf_raw;

   assign ovf_raw = stg[LAST].c_q ^ stg[LAST].cp_q;

`ifdef CLA_SATURATE_EN
   localparam logic [WIDTH-1:0] SMAX = CLA_SMAX_FULL[CLA_MAX_W-1 -: WIDTH];
   localparam logic [WIDTH-1:0] SMIN = ~SMAX;

   assign sum_fin = (stg[LAST].sat_q && ovf_raw)
                  ? (stg[LAST].a_q[WIDTH-1] ? SMIN : SMAX)
                  : stg[LAST].s_q;
`else
   assign sum_fin = stg[LAST].s_q;
`endif

   assign bus.out_valid = stg[LAST].vld;
   assign bus.sum       = sum_fin;
   assign bus.cout      = stg[LAST].c_q;
   assign bus.cout_prev = stg[LAST].cp_q;
   assign bus.ovf       = ovf_raw;
   // Qualified by valid so a cleared pipeline does not report zero=1.
   assign bus.zero      = stg[LAST].vld && (sum_fin == '0);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=16, GPS=1, latency 4).
module tb_cla_pipe_adder;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   cla_pipe_adder_if #(.WIDTH(16)) bif ();

   cla_pipe_adder #(.WIDTH(16), .GPS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin);
      bif.in_valid = 1'b1;
      bif.a        = a;
      bif.b        = b;
      bif.sub      = sub;
      bif.cin      = cin;
      #1;
      chk("send_in_ready", bif.in_ready, 1);
      tick();
      bif.in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] s, input logic co,
                             input logic cp, input logic ov, input logic z);
      chk({tag, "_valid"}, bif.out_valid, 1);
      chk({tag, "_sum"}, bif.sum, s);
      chk({tag, "_cout"}, bif.cout, co);
      chk({tag, "_cout_prev"}, bif.cout_prev, cp);
      chk({tag, "_ovf"}, bif.ovf, ov);
      chk({tag, "_zero"}, bif.zero, z);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nxt;
      int rcv;
      checks       = 0;
      failures     = 0;
      rst          = 1'b1;
      bif.in_valid = 1'b0;
      bif.a        = '0;
      bif.b        = '0;
      bif.cin      = 1'b0;
      bif.sub      = 1'b0;
      bif.out_ready = 1'b1;
`ifdef CLA_SATURATE_EN
      bif.sat      = 1'b0;
`endif

      // reset then idle
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", bif.out_valid, 0);
      chk("rst_sum", bif.sum, 0);
      chk("rst_cout", bif.cout, 0);
      chk("rst_cout_prev", bif.cout_prev, 0);
      chk("rst_ovf", bif.ovf, 0);
      chk("rst_zero", bif.zero, 0);
      chk("rst_in_ready", bif.in_ready, 1);
      @(negedge clk);

      // streaming adds, back-to-back results
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      chk("lat_e2_valid", bif.out_valid, 0);
      tick();
      chk("lat_e3_valid", bif.out_valid, 0);
      tick();
      expect_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      chk("add_drain_valid", bif.out_valid, 0);

      // subtract, cin ignored
      send(16'h0005, 16'h0007, 1'b1, 1'b1);
      send(16'h8000, 16'h0001, 1'b1, 1'b0);
      tick();
      tick();
      expect_out("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_out("sub_ovf", 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();

      // backpressure: out_ready low on cycles 5..7
      nxt = 1;
      rcv = 1;
      for (int cyc = 1; cyc <= 20 && rcv <= 6; cyc++) begin
         bif.in_valid  = (nxt <= 6);
         bif.a         = nxt[15:0];
         bif.b         = nxt[15:0];
         bif.sub       = 1'b0;
         bif.cin       = 1'b0;
         bif.out_ready = !(cyc >= 5 && cyc <= 7);
         #1;
         if (cyc >= 5 && cyc <= 7) begin
            chk("bp_in_ready", bif.in_ready, 0);
            chk("bp_hold_valid", bif.out_valid, 1);
            chk("bp_hold_sum", bif.sum, 2);
         end
         if (bif.out_valid && bif.out_ready) begin
            chk("bp_sum", bif.sum, 32'(2 * rcv));
            rcv++;
         end
         if (bif.in_valid && bif.in_ready) nxt++;
         tick();
      end
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      chk("bp_count", rcv, 7);
      tick();
      chk("bp_drain_valid", bif.out_valid, 0);

      // reset with beats in flight
      send(16'h0010, 16'h0010, 1'b0, 1'b0);
      send(16'h0020, 16'h0020, 1'b0, 1'b0);
      send(16'h0030, 16'h0030, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_valid", bif.out_valid, 0);
      send(16'h0001, 16'h0002, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("midrst_flush", bif.out_valid, 0);
         tick();
      end
      expect_out("midrst_next", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();

`ifdef CLA_SATURATE_EN
      bif.sat = 1'b1;
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send(16'h8000, 16'h0001, 1'b1, 1'b0);
      bif.sat = 1'b0;
      tick();
      tick();
      expect_out("sat_pos", 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      expect_out("sat_neg", 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
